mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single line-wide memory port.
// One transaction at a time; a one-cycle RELEASE gap separates grants and a cycle budget aborts stuck serves.
module mem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [LINE_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [LINE_W-1:0] req0_data_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [LINE_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [LINE_W-1:0] req1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              timeout_o
);
  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1, RELEASE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_grant;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_data;
  logic              r_timeout;

  logic w_serving;
  logic w_expire;
  logic w_done;
  logic w_grant_vld;
  logic w_grant;
  logic w_ack0;
  logic w_ack1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_serving   = (r_state == SERVE0) || (r_state == SERVE1);
    w_expire    = w_serving && !mem_ack_i && (r_cnt == CNT_LAST);
    w_done      = w_serving && (mem_ack_i || w_expire);
    w_grant_vld = req0_enable_i || req1_enable_i;
    // On a tie the port not granted last wins; a lone requester always wins.
    if (req0_enable_i && req1_enable_i) w_grant = ~r_last_grant;
    else                                w_grant = req1_enable_i;

    w_next = r_state;
    case (r_state)
      IDLE:           if (w_grant_vld) w_next = w_grant ? SERVE1 : SERVE0;
      SERVE0, SERVE1: if (w_done)      w_next = RELEASE;
      RELEASE:        w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_timeout    <= 1'b0;
    end else begin
      if (r_state == IDLE && w_grant_vld) begin
        r_cnt        <= '0;
        r_last_grant <= w_grant;
        r_write      <= w_grant ? req1_write_i : req0_write_i;
        r_addr       <= w_grant ? req1_addr_i  : req0_addr_i;
        r_data       <= w_grant ? req1_data_i  : req0_data_i;
      end else if (w_serving && r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_expire) r_timeout <= 1'b1;
    end
  end

  // A timeout still acks the requester, but with an all-zero line.
  always_comb begin
    w_ack0       = (r_state == SERVE0) && w_done;
    w_ack1       = (r_state == SERVE1) && w_done;
    req0_ack_o   = w_ack0;
    req1_ack_o   = w_ack1;
    req0_data_o  = (w_ack0 && mem_ack_i) ? mem_data_i : '0;
    req1_data_o  = (w_ack1 && mem_ack_i) ? mem_data_i : '0;
    mem_enable_o = w_serving;
    mem_write_o  = r_write;
    mem_addr_o   = r_addr;
    mem_data_o   = r_data;
    busy_o       = (r_state != IDLE);
    timeout_o    = r_timeout;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model of grant order, ack timing and the timeout flag.
module tb_mem_arbiter;
  localparam int TO = 16;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req0_enable_i = 1'b0, req0_write_i = 1'b0;
  logic [AW-1:0] req0_addr_i = '0;
  logic [LW-1:0] req0_data_i = '0;
  logic          req0_ack_o;
  logic [LW-1:0] req0_data_o;
  logic          req1_enable_i = 1'b0, req1_write_i = 1'b0;
  logic [AW-1:0] req1_addr_i = '0;
  logic [LW-1:0] req1_data_i = '0;
  logic          req1_ack_o;
  logic [LW-1:0] req1_data_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_data_o;
  logic          mem_ack_i = 1'b0;
  logic [LW-1:0] mem_data_i = '0;
  logic          busy_o, timeout_o;

  int n_cmp = 0;
  int n_fail = 0;
  int model_last = 1;
  bit model_to = 1'b0;

  mem_arbiter #(.TIMEOUT(TO), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i), .req0_addr_i(req0_addr_i),
    .req0_data_i(req0_data_i), .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o),
    .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i), .req1_addr_i(req1_addr_i),
    .req1_data_i(req1_data_i), .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic apply_reset();
    rst_i = 1'b0;
    req0_enable_i = 1'b0; req1_enable_i = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    model_last = 1;
    model_to   = 1'b0;
  endtask

  // Called in an IDLE cycle (just after an edge); returns with the DUT in IDLE again.
  // lat < 1 or lat > TO means the memory never acks.
  task automatic run_txn(input bit e0, input bit e1, input bit w0, input bit w1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [LW-1:0] d0, input logic [LW-1:0] d1,
                         input int lat, input logic [LW-1:0] rdata, input bit perturb,
                         output int obs_port, output int en_cycles);
    int gp, ack_cyc;
    bit is_to, exp_w, x0, x1;
    logic [AW-1:0] exp_a;
    logic [LW-1:0] exp_d, exp_rd, e0d, e1d;
    gp = (e0 && e1) ? ((model_last == 1) ? 0 : 1) : (e1 ? 1 : 0);
    model_last = gp;
    exp_w  = gp ? w1 : w0;
    exp_a  = gp ? a1 : a0;
    exp_d  = gp ? d1 : d0;
    is_to  = (lat < 1) || (lat > TO);
    ack_cyc = is_to ? TO : lat;
    exp_rd = is_to ? '0 : rdata;
    obs_port = -1; en_cycles = 0;
    req0_enable_i = e0; req0_write_i = w0; req0_addr_i = a0; req0_data_i = d0;
    req1_enable_i = e1; req1_write_i = w1; req1_addr_i = a1; req1_data_i = d1;
    for (int k = 1; k <= ack_cyc; k++) begin
      @(posedge clk_i); #1;
      mem_ack_i  = !is_to && (k == lat);
      mem_data_i = (k == lat) ? rdata : rnd_line();
      if (mem_enable_o === 1'b1) en_cycles++;
      n_cmp++; if (mem_enable_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++;
        $display("FAIL serve_en k=%0d: got en=%b busy=%b want 1/1", k, mem_enable_o, busy_o); end
      n_cmp++; if (mem_write_o !== exp_w || mem_addr_o !== exp_a) begin n_fail++;
        $display("FAIL serve_req k=%0d: got w=%b a=%h want w=%b a=%h", k, mem_write_o, mem_addr_o, exp_w, exp_a); end
      n_cmp++; if (mem_data_o !== exp_d) begin n_fail++;
        $display("FAIL serve_wdata k=%0d: got %h want %h", k, mem_data_o, exp_d); end
      #1;
      x0 = (gp == 0) && (k == ack_cyc);
      x1 = (gp == 1) && (k == ack_cyc);
      e0d = x0 ? exp_rd : '0;
      e1d = x1 ? exp_rd : '0;
      n_cmp++; if (req0_ack_o !== x0 || req1_ack_o !== x1) begin n_fail++;
        $display("FAIL req_ack k=%0d: got %b%b want %b%b", k, req0_ack_o, req1_ack_o, x0, x1); end
      n_cmp++; if (req0_data_o !== e0d) begin n_fail++;
        $display("FAIL req0_data k=%0d: got %h want %h", k, req0_data_o, e0d); end
      n_cmp++; if (req1_data_o !== e1d) begin n_fail++;
        $display("FAIL req1_data k=%0d: got %h want %h", k, req1_data_o, e1d); end
      if (k == ack_cyc) obs_port = (req0_ack_o === 1'b1) ? 0 : ((req1_ack_o === 1'b1) ? 1 : -1);
      if (k == 1 && perturb) begin
        req0_enable_i = $urandom_range(0, 1); req0_write_i = $urandom_range(0, 1);
        req0_addr_i = $urandom(); req0_data_i = rnd_line();
        req1_enable_i = $urandom_range(0, 1); req1_write_i = $urandom_range(0, 1);
        req1_addr_i = $urandom(); req1_data_i = rnd_line();
      end
    end
    n_cmp++; if (obs_port != gp) begin n_fail++;
      $display("FAIL grant: got port %0d want %0d", obs_port, gp); end
    if (is_to) model_to = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    req0_enable_i = 1'b1; req1_enable_i = 1'b1;
    n_cmp++; if (mem_enable_o !== 1'b0 || busy_o !== 1'b1 || timeout_o !== model_to) begin n_fail++;
      $display("FAIL release: got en=%b busy=%b to=%b want 0/1/%b", mem_enable_o, busy_o, timeout_o, model_to); end
    mem_ack_i = 1'b1; mem_data_i = rnd_line(); #1;
    n_cmp++; if (req0_ack_o !== 1'b0 || req1_ack_o !== 1'b0 || req0_data_o !== '0 || req1_data_o !== '0) begin n_fail++;
      $display("FAIL release_stray: got acks %b%b want 00", req0_ack_o, req1_ack_o); end
    @(posedge clk_i); #1;
    n_cmp++; if (busy_o !== 1'b0 || mem_enable_o !== 1'b0) begin n_fail++;
      $display("FAIL idle_return: got busy=%b en=%b want 0/0", busy_o, mem_enable_o); end
    #1;
    n_cmp++; if (req0_ack_o !== 1'b0 || req1_ack_o !== 1'b0 || req0_data_o !== '0 || req1_data_o !== '0) begin n_fail++;
      $display("FAIL idle_stray: got acks %b%b want 00", req0_ack_o, req1_ack_o); end
    mem_ack_i = 1'b0;
    req0_enable_i = 1'b0; req1_enable_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b0;
    #2;
    n_cmp++; if ({mem_enable_o, mem_write_o, req0_ack_o, req1_ack_o, busy_o, timeout_o} !== 6'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000", {mem_enable_o, mem_write_o, req0_ack_o, req1_ack_o, busy_o, timeout_o}); end
    n_cmp++; if (mem_addr_o !== '0 || mem_data_o !== '0 || req0_data_o !== '0 || req1_data_o !== '0) begin n_fail++;
      $display("FAIL reset_data: got addr=%h want 0", mem_addr_o); end
    apply_reset();
  endtask

  task automatic test_single_read();
    int p, en;
    logic [LW-1:0] line;
    line = 256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222_3333_4444_5555_6666_7777_0000;
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h0000_0020, '0, '0, 10, line, 1'b0, p, en);
    n_cmp++; if (p != 1 || en != 10) begin n_fail++;
      $display("FAIL single_read: got port=%0d en_cycles=%0d want 1/10", p, en); end
  endtask

  task automatic test_tie();
    int p0, p1, en;
    apply_reset();
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200, rnd_line(), rnd_line(), 3, rnd_line(), 1'b0, p0, en);
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200, rnd_line(), rnd_line(), 4, rnd_line(), 1'b0, p1, en);
    n_cmp++; if (p0 != 0 || p1 != 1) begin n_fail++;
      $display("FAIL tie_order: got %0d,%0d want 0,1", p0, p1); end
  endtask

  task automatic test_fairness();
    int p, en;
    int want[4] = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
              rnd_line(), rnd_line(), $urandom_range(1, 6), rnd_line(), 1'b0, p, en);
      n_cmp++; if (p != want[i]) begin n_fail++;
        $display("FAIL fairness[%0d]: got port %0d want %0d", i, p, want[i]); end
    end
  endtask

  task automatic test_latency_bounds();
    int p, en;
    int lats[3] = '{1, TO - 1, TO};
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b1, 1'b0, 1'b0, 1'b0, $urandom(), '0, rnd_line(), '0, lats[i], rnd_line(), 1'b0, p, en);
      n_cmp++; if (en != lats[i] || timeout_o !== 1'b0) begin n_fail++;
        $display("FAIL latency_%0d: got en_cycles=%0d to=%b want %0d/0", lats[i], en, timeout_o, lats[i]); end
    end
  endtask

  task automatic test_timeout();
    int p, en;
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h40, '0, '0, 0, rnd_line(), 1'b0, p, en);
    n_cmp++; if (en != TO || timeout_o !== 1'b1) begin n_fail++;
      $display("FAIL timeout: got en_cycles=%0d to=%b want %0d/1", en, timeout_o, TO); end
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h80, '0, rnd_line(), '0, 2, rnd_line(), 1'b0, p, en);
    n_cmp++; if (timeout_o !== 1'b1) begin n_fail++;
      $display("FAIL timeout_sticky: got %b want 1", timeout_o); end
  endtask

  task automatic test_reset_mid();
    int p, en;
    req0_enable_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h300;
    for (int k = 1; k <= 5; k++) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    n_cmp++; if (mem_enable_o !== 1'b0 || busy_o !== 1'b0 || req0_ack_o !== 1'b0 || req1_ack_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_mid: got en=%b busy=%b acks=%b%b want 0/0/00", mem_enable_o, busy_o, req0_ack_o, req1_ack_o); end
    n_cmp++; if (timeout_o !== 1'b0 || mem_addr_o !== '0) begin n_fail++;
      $display("FAIL reset_mid_regs: got to=%b addr=%h want 0/0", timeout_o, mem_addr_o); end
    apply_reset();
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0400, '0, rnd_line(), '0, 5, rnd_line(), 1'b0, p, en);
  endtask

  task automatic test_random();
    int p, en;
    bit e0, e1;
    for (int i = 0; i < 40; i++) begin
      e0 = $urandom_range(0, 1);
      e1 = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(e0, e1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
              rnd_line(), rnd_line(), $urandom_range(1, TO + 4), rnd_line(), 1'b1, p, en);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_fairness();
    test_latency_bounds();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
